// File: rtl/life_pkg.sv
// Shared types and default grid constants for the Game-of-Life generation controller.
package life_pkg;

    localparam int unsigned N_COLS   = 400;
    localparam int unsigned N_ROWS   = 300;
    localparam int unsigned CELL_CNT = N_COLS * N_ROWS;
    localparam int unsigned STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        STEP  = 3'd3,
        DRAIN = 3'd4,
        CLEAR = 3'd5
    } state_t;

    // One bit per button, highest priority first.
    typedef struct packed {
        logic clear;
        logic pause;
        logic start;
        logic step;
    } btn_edge_t;

    // Keep only the highest-priority edge: clear > pause > start > step.
    function automatic btn_edge_t edge_prio(input btn_edge_t e);
        btn_edge_t r;
        r = '0;
        if (e.clear) begin
            r.clear = 1'b1;
        end else if (e.pause) begin
            r.pause = 1'b1;
        end else if (e.start) begin
            r.start = 1'b1;
        end else if (e.step) begin
            r.step = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/life_tick_gen.sv
// Programmable evolution tick: period TICK_DIV >> speed_sel, counter held at zero when disabled.
module life_tick_gen #(
    parameter int unsigned TICK_DIV = 5000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] speed_sel,
    output logic       tick_c
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      period_c;
    logic [31:0]      limit_c;

    // Terminal count; >= so that a shorter period selected mid-count fires at once.
    assign period_c = 32'(TICK_DIV) >> speed_sel;
    assign limit_c  = (period_c == 32'd0) ? 32'd0 : (period_c - 32'd1);
    assign tick_c   = en && (32'(cnt_q) >= limit_c);

    // Cycle counter, cleared while disabled and on every tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (!en || tick_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/life_gen_ctrl.sv
// Generation controller: run/pause/step/clear, tick pacing, round handshake and buffer select.
module life_gen_ctrl #(
    parameter int unsigned ADDR_W   = 24,
    parameter int unsigned N_COLS   = life_pkg::N_COLS,
    parameter int unsigned N_ROWS   = life_pkg::N_ROWS,
    parameter int unsigned TICK_DIV = 5000000,
    parameter int unsigned GEN_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              btn_start,
    input  logic              btn_pause,
    input  logic              btn_step,
    input  logic              btn_clear,
    input  logic [1:0]        speed_sel,
    input  logic              round_done,
    output logic              round_go,
    output logic              buf_sel,
    output logic              clear_we,
    output logic [ADDR_W-1:0] clear_addr,
    output logic [2:0]        state,
    output logic [GEN_W-1:0]  gen_count,
    output logic              overrun
);

    localparam int unsigned       SWEEP_LEN = N_COLS * N_ROWS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SWEEP_LEN - 1);

    life_pkg::state_t    state_q;
    life_pkg::state_t    state_nxt;
    life_pkg::btn_edge_t btn_q;
    life_pkg::btn_edge_t btn_now;
    life_pkg::btn_edge_t raw_edge_c;
    life_pkg::btn_edge_t edge_c;

    logic              busy_q;
    logic              busy_nxt;
    logic              go_nxt;
    logic              buf_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [GEN_W-1:0]  gen_nxt;
    logic              ovr_nxt;
    logic              tick_c;
    logic              done_c;
    logic              busy_after_c;
    logic              run_en_c;

    // Rising-edge detect on the debounced levels, then priority filter.
    assign btn_now      = {btn_clear, btn_pause, btn_start, btn_step};
    assign raw_edge_c   = btn_now & ~btn_q;
    assign edge_c       = life_pkg::edge_prio(raw_edge_c);

    // A done only counts against an outstanding go; busy_after is busy as seen next cycle.
    assign done_c       = round_done & busy_q;
    assign busy_after_c = busy_q & ~round_done;
    assign run_en_c     = (state_q == life_pkg::RUN);
    assign state        = state_q;

    life_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (run_en_c),
        .speed_sel (speed_sel),
        .tick_c    (tick_c)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_nxt = state_q;
        busy_nxt  = busy_q;
        go_nxt    = 1'b0;
        buf_nxt   = buf_sel;
        gen_nxt   = gen_count;
        ovr_nxt   = overrun;
        we_nxt    = 1'b0;
        addr_nxt  = '0;

        if (done_c) begin
            busy_nxt = 1'b0;
            buf_nxt  = ~buf_sel;
            gen_nxt  = gen_count + GEN_W'(1);
        end

        case (state_q)
            life_pkg::IDLE: begin
                if (edge_c.clear) begin
                    state_nxt = life_pkg::CLEAR;
                    we_nxt    = 1'b1;
                end else if (edge_c.start) begin
                    state_nxt = life_pkg::RUN;
                end else if (edge_c.step) begin
                    state_nxt = life_pkg::STEP;
                    go_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            life_pkg::RUN: begin
                if (edge_c.clear) begin
                    if (busy_after_c) begin
                        state_nxt = life_pkg::DRAIN;
                    end else begin
                        state_nxt = life_pkg::CLEAR;
                        we_nxt    = 1'b1;
                    end
                end else if (edge_c.pause) begin
                    state_nxt = life_pkg::PAUSE;
                end else if (tick_c) begin
                    if (busy_q) begin
                        ovr_nxt  = 1'b1;
                    end else begin
                        go_nxt   = 1'b1;
                        busy_nxt = 1'b1;
                    end
                end
            end
            life_pkg::PAUSE: begin
                if (edge_c.clear) begin
                    if (busy_after_c) begin
                        state_nxt = life_pkg::DRAIN;
                    end else begin
                        state_nxt = life_pkg::CLEAR;
                        we_nxt    = 1'b1;
                    end
                end else if (edge_c.start) begin
                    state_nxt = life_pkg::RUN;
                end else if (edge_c.step && !busy_q) begin
                    state_nxt = life_pkg::STEP;
                    go_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            life_pkg::STEP: begin
                if (edge_c.clear) begin
                    if (busy_after_c) begin
                        state_nxt = life_pkg::DRAIN;
                    end else begin
                        state_nxt = life_pkg::CLEAR;
                        we_nxt    = 1'b1;
                    end
                end else if (done_c) begin
                    state_nxt = life_pkg::PAUSE;
                end
            end
            life_pkg::DRAIN: begin
                if (!busy_after_c) begin
                    state_nxt = life_pkg::CLEAR;
                    we_nxt    = 1'b1;
                end
            end
            life_pkg::CLEAR: begin
                if (clear_addr == LAST_ADDR) begin
                    state_nxt = life_pkg::IDLE;
                    busy_nxt  = 1'b0;
                    buf_nxt   = 1'b0;
                    gen_nxt   = '0;
                    ovr_nxt   = 1'b0;
                end else begin
                    we_nxt   = 1'b1;
                    addr_nxt = clear_addr + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = life_pkg::IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= life_pkg::IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Output, handshake and button-history registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q      <= '0;
            busy_q     <= 1'b0;
            round_go   <= 1'b0;
            buf_sel    <= 1'b0;
            gen_count  <= '0;
            overrun    <= 1'b0;
            clear_we   <= 1'b0;
            clear_addr <= '0;
        end else begin
            btn_q      <= btn_now;
            busy_q     <= busy_nxt;
            round_go   <= go_nxt;
            buf_sel    <= buf_nxt;
            gen_count  <= gen_nxt;
            overrun    <= ovr_nxt;
            clear_we   <= we_nxt;
            clear_addr <= addr_nxt;
        end
    end

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Bench for life_gen_ctrl: round_go cycle scoreboard plus directed state/output checks.
module tb_life_gen_ctrl;

    localparam int unsigned ADDR_W   = 24;
    localparam int unsigned GEN_W    = 16;
    localparam int unsigned TICK_DIV = 8;
    localparam int unsigned N_COLS   = 4;
    localparam int unsigned N_ROWS   = 3;
    localparam int          CELLS    = 12;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_STEP  = 3;
    localparam int S_DRAIN = 4;
    localparam int S_CLEAR = 5;

    localparam logic [3:0] B_CLEAR = 4'b1000;
    localparam logic [3:0] B_PAUSE = 4'b0100;
    localparam logic [3:0] B_START = 4'b0010;
    localparam logic [3:0] B_STEP  = 4'b0001;

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b0;
    logic              btn_start  = 1'b0;
    logic              btn_pause  = 1'b0;
    logic              btn_step   = 1'b0;
    logic              btn_clear  = 1'b0;
    logic [1:0]        speed_sel  = 2'd0;
    logic              round_done = 1'b0;
    logic              round_go;
    logic              buf_sel;
    logic              clear_we;
    logic [ADDR_W-1:0] clear_addr;
    logic [2:0]        state;
    logic [GEN_W-1:0]  gen_count;
    logic              overrun;

    int cyc      = 0;
    int n_vec    = 0;
    int n_err    = 0;
    int done_lat = 3;
    int pend     = 0;
    int exp_go_q[$];

    life_gen_ctrl #(
        .ADDR_W   (ADDR_W),
        .N_COLS   (N_COLS),
        .N_ROWS   (N_ROWS),
        .TICK_DIV (TICK_DIV),
        .GEN_W    (GEN_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_start  (btn_start),
        .btn_pause  (btn_pause),
        .btn_step   (btn_step),
        .btn_clear  (btn_clear),
        .speed_sel  (speed_sel),
        .round_done (round_done),
        .round_go   (round_go),
        .buf_sel    (buf_sel),
        .clear_we   (clear_we),
        .clear_addr (clear_addr),
        .state      (state),
        .gen_count  (gen_count),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", tag, cyc, obs, exp);
        end
    endtask

    // Round-engine stand-in: scoreboard pop on each go, done returned done_lat cycles later.
    always @(negedge clk) begin
        round_done = 1'b0;
        if (!reset_n) begin
            pend = 0;
        end else if (round_go) begin
            if (exp_go_q.size() == 0) chk("go_cyc", cyc, -1);
            else                      chk("go_cyc", cyc, exp_go_q.pop_front());
            if (done_lat == 0) round_done = 1'b1;
            else               pend = done_lat;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) round_done = 1'b1;
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] m);
        {btn_clear, btn_pause, btn_start, btn_step} = m;
        @(negedge clk);
        {btn_clear, btn_pause, btn_start, btn_step} = 4'b0000;
    endtask

    // Sweep starting with address 0 at cycle t0; optionally pokes start mid-sweep.
    task automatic check_sweep(input int t0, input bit poke);
        for (int i = 0; i < CELLS; i++) begin
            wait_until(t0 + i);
            if (poke && i == 4) btn_start = 1'b1;
            if (poke && i == 5) btn_start = 1'b0;
            chk("sweep_we", clear_we, 1);
            chk("sweep_addr", clear_addr, i);
            chk("sweep_state", state, S_CLEAR);
        end
        wait_until(t0 + CELLS);
        chk("post_sweep_state", state, S_IDLE);
        chk("post_sweep_we", clear_we, 0);
        chk("post_sweep_addr", clear_addr, 0);
        chk("post_sweep_buf", buf_sel, 0);
        chk("post_sweep_gen", gen_count, 0);
        chk("post_sweep_ovr", overrun, 0);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk("rst_state", state, S_IDLE);
        chk("rst_go", round_go, 0);
        chk("rst_buf", buf_sel, 0);
        chk("rst_gen", gen_count, 0);
        chk("rst_we", clear_we, 0);
        chk("rst_addr", clear_addr, 0);
        chk("rst_ovr", overrun, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Free run at full period, done after 3 cycles.
        t = cyc;
        exp_go_q.push_back(t + 9);
        exp_go_q.push_back(t + 17);
        press(B_START);
        wait_until(t + 2);
        chk("run_state", state, S_RUN);
        wait_until(t + 13);
        chk("gen1_buf", buf_sel, 1);
        chk("gen1_cnt", gen_count, 1);
        wait_until(t + 21);
        chk("gen2_buf", buf_sel, 0);
        chk("gen2_cnt", gen_count, 2);
        wait_until(t + 22);
        press(B_PAUSE);
        wait_until(t + 30);
        chk("pause_state", state, S_PAUSE);
        chk("pause_ovr", overrun, 0);

        // Fast run, then a slow round to provoke overruns.
        speed_sel = 2'd2;
        done_lat  = 0;
        t = cyc;
        exp_go_q.push_back(t + 3);
        exp_go_q.push_back(t + 5);
        exp_go_q.push_back(t + 7);
        exp_go_q.push_back(t + 15);
        press(B_START);
        wait_until(t + 6);
        done_lat = 5;
        chk("fast_ovr0", overrun, 0);
        wait_until(t + 10);
        chk("fast_ovr1", overrun, 1);
        wait_until(t + 15);
        press(B_PAUSE);
        wait_until(t + 17);
        press(B_STEP);
        wait_until(t + 19);
        chk("busy_step_state", state, S_PAUSE);
        wait_until(t + 21);
        chk("fast_gen", gen_count, 6);
        chk("fast_buf", buf_sel, 0);

        // Single step from PAUSE.
        done_lat = 3;
        t = cyc;
        exp_go_q.push_back(t + 1);
        press(B_STEP);
        wait_until(t + 2);
        chk("step_state", state, S_STEP);
        wait_until(t + 5);
        chk("step_done_state", state, S_PAUSE);
        chk("step_gen", gen_count, 7);
        chk("step_buf", buf_sel, 1);

        // Clear from PAUSE (start poked mid-sweep), then clear from IDLE.
        t = cyc;
        press(B_CLEAR);
        check_sweep(t + 1, 1'b1);
        t = cyc;
        press(B_CLEAR);
        check_sweep(t + 1, 1'b0);

        // Clear while a round is in flight drains first.
        speed_sel = 2'd0;
        done_lat  = 6;
        t = cyc;
        exp_go_q.push_back(t + 9);
        press(B_START);
        wait_until(t + 11);
        press(B_CLEAR);
        wait_until(t + 13);
        chk("drain_state", state, S_DRAIN);
        chk("drain_we", clear_we, 0);
        wait_until(t + 16);
        chk("drain_buf", buf_sel, 1);
        chk("drain_gen", gen_count, 1);
        check_sweep(t + 16, 1'b0);

        // Edge priority: pause beats start in RUN, start beats step in PAUSE.
        done_lat = 2;
        t = cyc;
        press(B_START);
        wait_until(t + 3);
        press(B_PAUSE | B_START);
        wait_until(t + 5);
        chk("prio_pause", state, S_PAUSE);
        wait_until(t + 6);
        press(B_START | B_STEP);
        wait_until(t + 8);
        chk("prio_start", state, S_RUN);
        press(B_PAUSE);
        wait_until(t + 10);
        chk("prio_repause", state, S_PAUSE);

        // Step to dirty buf_sel/gen_count, then reset in the middle of a sweep.
        t = cyc;
        exp_go_q.push_back(t + 1);
        press(B_STEP);
        wait_until(t + 5);
        chk("pre_rst_buf", buf_sel, 1);
        chk("pre_rst_gen", gen_count, 1);
        t = cyc;
        press(B_CLEAR);
        wait_until(t + 5);
        chk("mid_sweep_addr", clear_addr, 4);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_state", state, S_IDLE);
        chk("arst_we", clear_we, 0);
        chk("arst_addr", clear_addr, 0);
        chk("arst_buf", buf_sel, 0);
        chk("arst_gen", gen_count, 0);
        chk("arst_go", round_go, 0);
        chk("arst_ovr", overrun, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("go_missing", exp_go_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/life_gen_ctrl.md
Name: life_gen_ctrl

Overview:
- Generation controller for the Game-of-Life datapath. Replaces the fixed 1 Hz toggle and hard-wired ping-pong logic in the top level.
- Owns run/pause/single-step/clear control, a programmable evolution tick and the buffer-select bit.
- Sequences the round engine with a go/done handshake.
- Provides a clear sweep that zeroes both frame buffers.
- Sits between the board buttons and the Round engine / RAM address-select muxes.

Parameters:
- ADDR_W, 24, cell address width.
- N_COLS, 400, cells per row.
- N_ROWS, 300, rows.
- TICK_DIV, 5000000, clk cycles per generation at speed_sel=0.
- GEN_W, 16, generation counter width.

Ports:
- clk  in  1  pixel/system clock
- reset_n  in  1  asynchronous active-low reset
- btn_start  in  1  debounced, clk-synchronous level
- btn_pause  in  1  debounced level
- btn_step  in  1  debounced level
- btn_clear  in  1  debounced level
- speed_sel  in  2  tick period = TICK_DIV >> speed_sel
- round_done  in  1  one-cycle pulse from Round: generation fully written
- round_go  out  1  one-cycle pulse: start one generation
- buf_sel  out  1  0: evolve-read bank A / write bank B; 1: swapped
- clear_we  out  1  write-enable for both banks during sweep
- clear_addr  out  ADDR_W  sweep address
- state  out  3  current FSM state (encoding from package)
- gen_count  out  GEN_W  completed generations, wraps
- overrun  out  1  sticky: tick arrived while a round was busy

Behaviour:
- Reset (async, reset_n=0): state=IDLE, buf_sel=0, gen_count=0, round_go=0, clear_we=0, clear_addr=0, overrun=0, tick counter=0, busy=0, all btn_prev=0.
- Edge detect: X_edge = btn_X & ~btn_X_prev. btn_prev is registered every cycle. The transition happens at the same clock edge that first samples the level high.
- Edge priority in one cycle: clear > pause > start > step. Lower-priority edges in the same cycle are dropped.
- busy: set when round_go=1, cleared by round_done. round_done while busy=0 is ignored and has no effect.
- Completion: on round_done with busy=1, toggle buf_sel and increment gen_count (mod 2^GEN_W) in the same cycle.
- Tick:
  - Counter runs only in RUN. It is zeroed on entry to RUN.
  - tick=1 when cnt >= (TICK_DIV>>speed_sel)-1; the counter then wraps to 0.
  - A speed_sel decrease mid-count therefore fires on the next cycle.
- FSM:
  - IDLE: start_edge -> RUN. step_edge -> STEP. clear_edge -> CLEAR.
  - RUN:
    - On tick with busy=0: round_go pulse.
    - On tick with busy=1: set overrun; the tick is dropped.
    - pause_edge -> PAUSE. An in-flight round completes normally and still toggles buf_sel.
    - clear_edge -> DRAIN if busy, else CLEAR.
  - PAUSE:
    - start_edge -> RUN.
    - step_edge with busy=0 -> STEP; with busy=1 it is ignored.
    - clear_edge -> DRAIN/CLEAR as in RUN.
  - STEP:
    - Issue round_go on the first cycle in STEP.
    - On round_done -> PAUSE.
    - clear_edge -> DRAIN.
    - Other edges are ignored.
  - DRAIN:
    - No round_go. Wait for round_done; buf_sel/gen_count update as normal, then -> CLEAR.
    - All buttons are ignored.
  - CLEAR:
    - clear_we=1, clear_addr counts 0 .. N_COLS*N_ROWS-1, one per cycle.
    - The cycle after the last address: clear_we=0, clear_addr=0, buf_sel=0, gen_count=0, overrun=0, -> IDLE.
    - Buttons are ignored. Sweep length is exactly N_COLS*N_ROWS cycles.
- round_go never asserts while busy=1 or in CLEAR/DRAIN. round_go is always a single cycle.
- Reset mid-sweep or mid-round: immediate return to reset values. The Round engine is reset by the same reset_n.

Decomposition:
- Package life_pkg: state enum (IDLE, RUN, PAUSE, STEP, DRAIN, CLEAR), default grid constants N_COLS/N_ROWS, CELL_CNT = N_COLS*N_ROWS.
- One natural sub-module: life_tick_gen (counter, speed_sel shift, enable, tick pulse).

Test Plan (TICK_DIV=8, N_COLS=4, N_ROWS=3):
- Reset, start_edge, round_done returned 3 cycles after each go -> round_go every 8 cycles; buf_sel toggles 0->1->0; gen_count 1, 2.
- RUN with speed_sel=2 -> round_go every 2 cycles. Round_done delayed 5 cycles -> overrun=1 and no round_go while busy.
- PAUSE, then step_edge -> exactly one round_go. After done: state=PAUSE, gen_count+1. A second step_edge while busy is ignored.
- clear_edge in IDLE -> clear_we high 12 cycles, clear_addr 0..11. Then IDLE, buf_sel=0, gen_count=0.
- clear_edge while busy in RUN -> DRAIN, no round_go. On round_done buf_sel toggles, then a 12-cycle sweep ends with buf_sel=0.
- Simultaneous pause_edge+start_edge in RUN -> PAUSE. reset_n low mid-CLEAR -> all outputs return to reset values asynchronously.
